// File: rtl/div11_digit_loader_if.sv
// -----------------------------------------------------------------------------
// div11_digit_loader_if
//   Bundles the digit-entry and number-output handshakes of the
//   divisible-by-11 digit loader.
//
//   Upstream side:
//     clear      abort the partial or complete number
//     in_valid   in_digit is offered
//     in_digit   BCD digit offered
//     in_ready   loader can take a digit
//     digit_err  pulse: an offered non-BCD code was dropped
//     timeout    pulse: a partial entry was abandoned
//   Downstream side:
//     out_valid  a..d hold a complete 4-digit number
//     out_ack    consumer has taken the number
//     a..d       thousands .. units digits
//     count      digits currently held (0..4)
//     rem11      running value mod 11 (0 when the remainder tracker is absent)
//
//   master: the environment (digit source and number consumer)
//   slave : the loader
// -----------------------------------------------------------------------------
interface div11_digit_loader_if;
  logic       clear;
  logic       in_valid;
  logic [3:0] in_digit;
  logic       in_ready;
  logic       out_valid;
  logic       out_ack;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] c;
  logic [3:0] d;
  logic [2:0] count;
  logic       digit_err;
  logic       timeout;
  logic [3:0] rem11;

  modport master (
    output clear, in_valid, in_digit, out_ack,
    input  in_ready, out_valid, a, b, c, d, count, digit_err, timeout, rem11
  );

  modport slave (
    input  clear, in_valid, in_digit, out_ack,
    output in_ready, out_valid, a, b, c, d, count, digit_err, timeout, rem11
  );
endinterface

// File: rtl/div11_digit_loader.sv
// -----------------------------------------------------------------------------
// div11_digit_loader
//   Upstream stage of the divisible-by-11 checker. Takes BCD digits one at a
//   time (most significant first), drops non-BCD codes with a digit_err pulse,
//   and presents the assembled 4-digit number on a..d with out_valid until the
//   consumer acknowledges it. A partially entered number is abandoned after
//   TIMEOUT idle cycles.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    div11_digit_loader_if.slave (see interface for signal list)
//
//   Parameters:
//     TIMEOUT  idle cycles allowed between digits while partially loaded
//              (0 disables the timeout)
//     TO_W     idle counter width; TIMEOUT must be < 2**TO_W
//
//   Build option:
//     DIV11_REM_EN  when defined, rem11 tracks the entered value mod 11;
//                   otherwise rem11 is tied to zero.
// -----------------------------------------------------------------------------
module div11_digit_loader #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TO_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  div11_digit_loader_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,   // no digits held
    ST_LOAD = 2'd1,   // 1..3 digits held
    ST_FULL = 2'd2    // 4 digits held, number presented downstream
  } state_e;

  localparam bit            TO_EN     = (TIMEOUT != 0);
  // Expiry is detected one cycle early so the counter "reaches" TIMEOUT on
  // the same edge that abandons the entry.
  localparam logic [TO_W-1:0] IDLE_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [3:0]      slot_q [4];
  logic [3:0]      slot_d [4];
  logic [2:0]      count_q, count_d;
  logic [TO_W-1:0] idle_q, idle_d;
  logic            digit_err_q, digit_err_d;
  logic            timeout_q, timeout_d;

  logic            accept;
  logic            digit_ok;
  logic            valid_accept;
  logic            wipe;          // return to the empty state this edge

  assign accept       = bus.in_valid & bus.in_ready;
  assign digit_ok     = (bus.in_digit <= 4'd9);
  assign valid_accept = accept & digit_ok;

  // ---------------------------------------------------------------------------
  // Next-state / datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    state_d     = state_q;
    slot_d      = slot_q;
    count_d     = count_q;
    idle_d      = idle_q;
    digit_err_d = 1'b0;
    timeout_d   = 1'b0;
    wipe        = 1'b0;

    if (bus.clear) begin
      // Abort outranks accept, ack and expiry, and raises no pulse.
      wipe = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_LOAD: begin
          if (valid_accept) begin
            slot_d[count_q[1:0]] = bus.in_digit;
            count_d              = count_q + 3'd1;
            idle_d               = '0;
            state_d              = (count_q == 3'd3) ? ST_FULL : ST_LOAD;
          end else begin
            // A dropped non-BCD code still completes the handshake but does
            // not count as activity for the idle counter.
            digit_err_d = accept;
            if (TO_EN && (state_q == ST_LOAD)) begin
              if (idle_q == IDLE_LAST) begin
                wipe      = 1'b1;
                timeout_d = 1'b1;
              end else begin
                idle_d = idle_q + 1'b1;
              end
            end
          end
        end

        ST_FULL: begin
          // in_ready is low here, so no digit can sneak in with the ack.
          if (bus.out_ack) begin
            wipe = 1'b1;
          end
        end

        default: begin
          wipe = 1'b1;
        end
      endcase
    end

    if (wipe) begin
      state_d = ST_IDLE;
      count_d = '0;
      idle_d  = '0;
      for (int i = 0; i < 4; i++) begin
        slot_d[i] = 4'd0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      idle_q      <= '0;
      digit_err_q <= 1'b0;
      timeout_q   <= 1'b0;
      // NOTE: the slot array is reset, unlike a typical storage array,
      // because unwritten slots must read as zero downstream.
      for (int i = 0; i < 4; i++) begin
        slot_q[i] <= 4'd0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of every other register.
      state_q     <= state_d;
      count_q     <= count_d;
      idle_q      <= idle_d;
      digit_err_q <= digit_err_d;
      timeout_q   <= timeout_d;
      slot_q      <= slot_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Running remainder mod 11
  // ---------------------------------------------------------------------------
`ifdef DIV11_REM_EN
  logic [3:0] rem_q, rem_d, rem_step;

  // Appending digit x to value v gives 10v + x; since 10 = -1 (mod 11) the
  // new remainder is (x - r) mod 11. The sum is formed in 5 bits because
  // x + 11 can exceed 15 before the subtraction.
  always_comb begin
    if (bus.in_digit >= rem_q) begin
      rem_step = bus.in_digit - rem_q;
    end else begin
      rem_step = 4'(5'(bus.in_digit) + 5'd11 - 5'(rem_q));
    end
  end

  always_comb begin
    rem_d = rem_q;
    if (wipe) begin
      rem_d = 4'd0;
    end else if (valid_accept) begin
      rem_d = rem_step;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= 4'd0;
    end else begin
      rem_q <= rem_d;
    end
  end

  assign bus.rem11 = rem_q;
`else
  assign bus.rem11 = 4'd0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.in_ready  = (state_q != ST_FULL);
  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.a         = slot_q[0];
  assign bus.b         = slot_q[1];
  assign bus.c         = slot_q[2];
  assign bus.d         = slot_q[3];
  assign bus.count     = count_q;
  assign bus.digit_err = digit_err_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_div11_digit_loader.sv
// -----------------------------------------------------------------------------
// tb_div11_digit_loader
//   Self-checking bench for div11_digit_loader (TIMEOUT = 8). A table of
//   single-cycle vectors covers entry, invalid codes, FULL hold/ack and clear;
//   hand-written sequences cover timeout, clear priority and async reset.
//   Outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_div11_digit_loader;

  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  div11_digit_loader_if bus_if ();

  div11_digit_loader #(.TIMEOUT(TIMEOUT), .TO_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        clr;
    logic        vld;
    logic [3:0]  dig;
    logic        ack;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (rdy,ov,a,b,c,d,cnt,err,to,rem)", name, got, exp);
    end
  endtask

  // Packed observation: {pad, in_ready, out_valid, a, b, c, d, count, digit_err, timeout, rem11}
  function automatic logic [31:0] snap();
    return {5'd0, bus_if.in_ready, bus_if.out_valid, bus_if.a, bus_if.b, bus_if.c, bus_if.d,
            bus_if.count, bus_if.digit_err, bus_if.timeout, bus_if.rem11};
  endfunction

  function automatic logic [31:0] pack(input logic r, input logic ov,
                                       input logic [3:0] a, input logic [3:0] b,
                                       input logic [3:0] c, input logic [3:0] d,
                                       input logic [2:0] cnt, input logic err,
                                       input logic to, input logic [3:0] rem);
    logic [3:0] rem_exp;
`ifdef DIV11_REM_EN
    rem_exp = rem;
`else
    rem_exp = 4'd0;
`endif
    return {5'd0, r, ov, a, b, c, d, cnt, err, to, rem_exp};
  endfunction

  function automatic vec_t mk(input logic clr, input logic vld, input logic [3:0] dig,
                              input logic ack, input logic [31:0] exp);
    vec_t v;
    v.clr = clr; v.vld = vld; v.dig = dig; v.ack = ack; v.exp = exp;
    return v;
  endfunction

  task automatic drive(input logic clr, input logic vld, input logic [3:0] dig, input logic ack);
    bus_if.clear    = clr;
    bus_if.in_valid = vld;
    bus_if.in_digit = dig;
    bus_if.out_ack  = ack;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one valid digit for one cycle, then go quiet.
  task automatic load(input logic [3:0] dig);
    drive(1'b0, 1'b1, dig, 1'b0);
    step();
    drive(1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  logic [31:0] zero_st;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    zero_st = pack(1, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0);

    // ---------------- vector table ----------------
    // 1,2,3,4 back-to-back, then ack
    vecs.push_back(mk(0, 1, 4'd1, 0, pack(1, 0, 1, 0, 0, 0, 3'd1, 0, 0, 4'd1)));
    vecs.push_back(mk(0, 1, 4'd2, 0, pack(1, 0, 1, 2, 0, 0, 3'd2, 0, 0, 4'd1)));
    vecs.push_back(mk(0, 1, 4'd3, 0, pack(1, 0, 1, 2, 3, 0, 3'd3, 0, 0, 4'd2)));
    vecs.push_back(mk(0, 1, 4'd4, 0, pack(0, 1, 1, 2, 3, 4, 3'd4, 0, 0, 4'd2)));
    vecs.push_back(mk(0, 0, 4'd0, 1, zero_st));
    // 1,2,1,0 (1210 = 110*11), hold 5 cycles with a digit offered, then ack
    vecs.push_back(mk(0, 1, 4'd1, 0, pack(1, 0, 1, 0, 0, 0, 3'd1, 0, 0, 4'd1)));
    vecs.push_back(mk(0, 1, 4'd2, 0, pack(1, 0, 1, 2, 0, 0, 3'd2, 0, 0, 4'd1)));
    vecs.push_back(mk(0, 1, 4'd1, 0, pack(1, 0, 1, 2, 1, 0, 3'd3, 0, 0, 4'd0)));
    vecs.push_back(mk(0, 1, 4'd0, 0, pack(0, 1, 1, 2, 1, 0, 3'd4, 0, 0, 4'd0)));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 1, 4'd7, 0, pack(0, 1, 1, 2, 1, 0, 3'd4, 0, 0, 4'd0)));
    vecs.push_back(mk(0, 0, 4'd0, 1, zero_st));
    // 5, invalid 12, 7 (57 mod 11 = 2), then clear
    vecs.push_back(mk(0, 1, 4'd5,  0, pack(1, 0, 5, 0, 0, 0, 3'd1, 0, 0, 4'd5)));
    vecs.push_back(mk(0, 1, 4'd12, 0, pack(1, 0, 5, 0, 0, 0, 3'd1, 1, 0, 4'd5)));
    vecs.push_back(mk(0, 1, 4'd7,  0, pack(1, 0, 5, 7, 0, 0, 3'd2, 0, 0, 4'd2)));
    vecs.push_back(mk(1, 0, 4'd0,  0, zero_st));
    // 9,0,0,9 (9009 = 819*11); digit 3 with ack in FULL is refused, taken next cycle
    vecs.push_back(mk(0, 1, 4'd9, 0, pack(1, 0, 9, 0, 0, 0, 3'd1, 0, 0, 4'd9)));
    vecs.push_back(mk(0, 1, 4'd0, 0, pack(1, 0, 9, 0, 0, 0, 3'd2, 0, 0, 4'd2)));
    vecs.push_back(mk(0, 1, 4'd0, 0, pack(1, 0, 9, 0, 0, 0, 3'd3, 0, 0, 4'd9)));
    vecs.push_back(mk(0, 1, 4'd9, 0, pack(0, 1, 9, 0, 0, 9, 3'd4, 0, 0, 4'd0)));
    vecs.push_back(mk(0, 1, 4'd3, 1, zero_st));
    vecs.push_back(mk(0, 1, 4'd3, 0, pack(1, 0, 3, 0, 0, 0, 3'd1, 0, 0, 4'd3)));
    vecs.push_back(mk(1, 0, 4'd0, 0, zero_st));
    // invalid 15 in IDLE, ack outside FULL ignored
    vecs.push_back(mk(0, 1, 4'd15, 0, pack(1, 0, 0, 0, 0, 0, 3'd0, 1, 0, 4'd0)));
    vecs.push_back(mk(0, 0, 4'd0,  1, zero_st));

    // ---------------- reset ----------------
    drive(1'b0, 1'b0, 4'd0, 1'b0);
    rst_n = 1'b0;
    #12;
    check("reset_hold", snap(), zero_st);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("reset_release", snap(), zero_st);

    // ---------------- table ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].clr, vecs[i].vld, vecs[i].dig, vecs[i].ack);
      step();
      check($sformatf("vec%0d", i), snap(), vecs[i].exp);
    end
    drive(1'b0, 1'b0, 4'd0, 1'b0);
    step();

    // ---------------- timeout after 8 idle cycles ----------------
    load(4'd9);
    load(4'd9);
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i < 8) check($sformatf("to_wait%0d", i), snap(), pack(1, 0, 9, 9, 0, 0, 3'd2, 0, 0, 4'd0));
      else       check("to_fire", snap(), pack(1, 0, 0, 0, 0, 0, 3'd0, 0, 1, 4'd0));
    end
    step();
    check("to_pulse_end", snap(), zero_st);
    for (int i = 0; i < 3; i++) step();
    check("to_none_in_idle", snap(), zero_st);

    // ---------------- digit at idle cycle 7 rescues entry ----------------
    load(4'd9);
    load(4'd9);
    for (int i = 0; i < 7; i++) step();
    load(4'd5);
    check("to_rescue", snap(), pack(1, 0, 9, 9, 5, 0, 3'd3, 0, 0, 4'd5));
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 7) check("to_restart7", snap(), pack(1, 0, 9, 9, 5, 0, 3'd3, 0, 0, 4'd5));
      if (i == 8) check("to_restart8", snap(), pack(1, 0, 0, 0, 0, 0, 3'd0, 0, 1, 4'd0));
    end

    // ---------------- invalid code does not restart idle counter ----------------
    load(4'd1);
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, (i == 4), 4'd12, 1'b0);
      step();
      if (i == 4) check("to_inv_err", snap(), pack(1, 0, 1, 0, 0, 0, 3'd1, 1, 0, 4'd1));
      if (i == 8) check("to_inv_fire", snap(), pack(1, 0, 0, 0, 0, 0, 3'd0, 0, 1, 4'd0));
    end
    drive(1'b0, 1'b0, 4'd0, 1'b0);
    step();

    // ---------------- clear beats expiry ----------------
    load(4'd1);
    for (int i = 0; i < 7; i++) step();
    drive(1'b1, 1'b0, 4'd0, 1'b0);
    step();
    check("clr_vs_to", snap(), zero_st);
    drive(1'b0, 1'b0, 4'd0, 1'b0);
    step();
    check("clr_vs_to_after", snap(), zero_st);

    // ---------------- clear beats a valid digit ----------------
    load(4'd4);
    load(4'd4);
    check("clr_pre", snap(), pack(1, 0, 4, 4, 0, 0, 3'd2, 0, 0, 4'd0));
    drive(1'b1, 1'b1, 4'd6, 1'b0);
    step();
    check("clr_vs_accept", snap(), zero_st);
    drive(1'b0, 1'b0, 4'd0, 1'b0);
    step();
    check("clr_after", snap(), zero_st);

    // ---------------- async reset mid-cycle ----------------
    load(4'd2);
    check("rst_pre", snap(), pack(1, 0, 2, 0, 0, 0, 3'd1, 0, 0, 4'd2));
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_async", snap(), zero_st);
    #2;
    rst_n = 1'b1;
    step();
    check("rst_after", snap(), zero_st);
    load(4'd8);
    check("rst_reentry", snap(), pack(1, 0, 8, 0, 0, 0, 3'd1, 0, 0, 4'd8));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div11_digit_loader.md
Name: div11_digit_loader

Overview:
- Upstream stage of the divisible-by-11 checker.
- Accepts decimal (BCD) digits one at a time over a valid/ready handshake and rejects non-BCD codes.
- Assembles a 4-digit number and presents it as parallel digits a (thousands) .. d (units) with an output valid/ack handshake for the combinational checker downstream.
- Abandons a partially entered number after an idle timeout.

Parameters:
- TIMEOUT, default 16: idle cycles allowed between accepted digits while partially loaded. 0 disables the timeout.
- TO_W, default 8: width of the idle counter. TIMEOUT must be < 2^TO_W.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous abort; discards the partial or complete number
- in_valid  input  1  in_digit is offered
- in_digit  input  4  BCD digit offered
- in_ready  output  1  loader can take a digit
- out_valid  output  1  a,b,c,d hold a complete 4-digit number
- out_ack  input  1  consumer has taken the number
- a  output  4  thousands digit (first entered)
- b  output  4  hundreds digit
- c  output  4  tens digit
- d  output  4  units digit (last entered)
- count  output  3  digits held, 0..4
- digit_err  output  1  one-cycle pulse: in_digit > 9 was offered and dropped
- timeout  output  1  one-cycle pulse: partial entry abandoned
- rem11  output  4  running value mod 11 (see Optional Feature)

Behaviour:
- Reset (rst_n low, async): state IDLE. a,b,c,d=0, count=0, out_valid=0, digit_err=0, timeout=0, rem11=0, idle counter=0. in_ready=1 after reset release.
- States:
  - IDLE: count=0.
  - LOAD: count 1..3.
  - FULL: count=4, out_valid=1.
- in_ready = 1 in IDLE/LOAD, 0 in FULL (combinational from state).
- Accept = in_valid & in_ready.
- Valid accept (in_digit <= 9):
  - digit written to slot[count] (0→a, 1→b, 2→c, 3→d); count += 1 on the same edge.
  - IDLE→LOAD; LOAD→LOAD for count<3; 4th digit → FULL.
  - out_valid rises the cycle after the 4th digit is accepted (registered).
- Invalid accept (in_digit 10..15):
  - digit consumed (handshake completes); registers and count unchanged.
  - digit_err=1 for the next cycle only.
  - idle counter is not reset.
- FULL:
  - a..d stable.
  - out_ack → IDLE on the next edge: a..d, count and rem11 cleared.
  - out_ack outside FULL is ignored.
  - in_valid in FULL is never accepted, including the cycle out_ack is high. The first digit can be taken the cycle after return to IDLE.
- Timeout (TIMEOUT>0, LOAD only):
  - idle counter increments each cycle without a valid accept; cleared on a valid accept and on leaving LOAD.
  - when the counter reaches TIMEOUT: → IDLE, a..d/count/rem11 cleared, timeout=1 for one cycle.
  - no timeout in IDLE or FULL.
- clear: synchronous, priority over every other event including a simultaneous accept, ack or timeout expiry. → IDLE, all data cleared, no digit_err/timeout pulse.
- Reset mid-entry or in FULL: immediate asynchronous return to the reset state; the partial number is lost.
- Slots not yet written read 0, so the downstream checker sees leading-digit-aligned zeros for unwritten lower slots.

Optional Feature:
- Macro DIV11_REM_EN.
- Defined:
  - rem11 tracks (number entered so far) mod 11.
  - On each valid accept: rem11' = (in_digit − rem11) mod 11, computed as in_digit ≥ rem11 ? in_digit − rem11 : in_digit − rem11 + 11. This follows from 10 ≡ −1 mod 11.
  - Cleared with the data.
  - In FULL, rem11==0 iff the number is divisible by 11; used to cross-check the checker's output.
- Undefined: rem11 tied to 4'd0. No remainder logic synthesised.

Test Plan:
- Reset, enter 1,2,3,4 back-to-back:
  - a=1, b=2, c=3, d=4; count=4.
  - out_valid=1 one cycle after the 4th accept; in_ready=0.
  - rem11=2 with DIV11_REM_EN, else 0.
- Enter 1,2,1,0 → rem11=0 (1210 = 110·11). Hold out_ack low 5 cycles → outputs stable. Pulse out_ack → next cycle IDLE, a..d=0, in_ready=1.
- Enter 5, then offer 12, then 7:
  - 12 consumed; digit_err pulses one cycle.
  - count goes 1 → 1 → 2; a=5, b=7.
- In FULL, assert in_valid with digit 3 together with out_ack:
  - digit not accepted.
  - next cycle IDLE, count=0.
  - digit 3 accepted on the following cycle → a=3.
- TIMEOUT=8: enter 9,9, then idle:
  - timeout pulses when the idle counter reaches 8.
  - state IDLE, count=0, a=b=0.
  - re-test with a digit arriving at idle cycle 7 → no timeout, count=3.
- Enter 4,4 then clear concurrent with a valid digit → IDLE, digit dropped. Enter 2, then drop rst_n mid-cycle → all outputs 0 immediately.
